// File: rtl/tx_nco_seq_ctrl_pkg.sv
// Shared types, default sizes and saturating slew helper for the TX NCO sequencer.
// The slew path is only used in builds with TX_NCO_RAMP_EN defined.
package tx_nco_seq_ctrl_pkg;

  localparam int unsigned APR_DEF        = 32;
  localparam int unsigned LAT_DEF        = 8;
  localparam int unsigned RAMP_SHIFT_DEF = 12;

  // Slew arithmetic is carried out at a fixed width wide enough for any APR up to SAT_W.
  localparam int unsigned SAT_W  = 64;
  localparam int unsigned SAT_XW = SAT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    SLEW = 2'd3
  } state_e;

  // One slew step from cur toward tgt; lands exactly on tgt once within one step.
  // The step always moves toward tgt, so the result never leaves the [cur, tgt] span.
  function automatic logic signed [SAT_W-1:0] sat_step(
    input logic signed [SAT_W-1:0] cur,
    input logic signed [SAT_W-1:0] tgt,
    input int unsigned             shift
  );
    logic signed [SAT_W:0] d;
    logic signed [SAT_W:0] mag;
    logic signed [SAT_W:0] step;
    step = SAT_XW'(1) << shift;
    d    = SAT_XW'(tgt) - SAT_XW'(cur);
    mag  = d[SAT_W] ? -d : d;
    if (mag <= step) begin
      return tgt;
    end
    if (d[SAT_W]) begin
      return cur - step[SAT_W-1:0];
    end
    return cur + step[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/tx_nco_seq_ctrl_if.sv
// Control/NCO-side signal bundle of the TX NCO sequencer.
// master = control side and NCO feedback (drives inputs), slave = sequencer.
interface tx_nco_seq_ctrl_if #(
  parameter int unsigned APR = tx_nco_seq_ctrl_pkg::APR_DEF
);
  logic           en_i;
  logic           freq_valid_i;
  logic           freq_ready_o;
  logic [APR-1:0] freq_i;
  logic           nco_valid_i;
  logic           nco_clken_o;
  logic           nco_srst_o;
  logic [APR-1:0] phi_inc_o;
  logic           iq_valid_o;
  logic           busy_o;

  modport master (
    output en_i, freq_valid_i, freq_i, nco_valid_i,
    input  freq_ready_o, nco_clken_o, nco_srst_o, phi_inc_o, iq_valid_o, busy_o
  );

  modport slave (
    input  en_i, freq_valid_i, freq_i, nco_valid_i,
    output freq_ready_o, nco_clken_o, nco_srst_o, phi_inc_o, iq_valid_o, busy_o
  );
endinterface

// File: rtl/tx_nco_seq_ctrl_slew.sv
// Combinational next phase increment for the frequency slew (ramp build only).
module tx_nco_seq_ctrl_slew
  import tx_nco_seq_ctrl_pkg::*;
#(
  parameter int unsigned APR        = APR_DEF,
  parameter int unsigned RAMP_SHIFT = RAMP_SHIFT_DEF
) (
  input  logic [APR-1:0] cur,
  input  logic [APR-1:0] tgt,
  output logic [APR-1:0] phi_nxt_c
);
  logic signed [SAT_W-1:0] cur_x;
  logic signed [SAT_W-1:0] tgt_x;

  // Sign-extend to the helper width; the result always fits back into APR bits.
  always_comb begin
    cur_x     = SAT_W'($signed(cur));
    tgt_x     = SAT_W'($signed(tgt));
    phi_nxt_c = APR'(sat_step(cur_x, tgt_x, RAMP_SHIFT));
  end
endmodule

// File: rtl/tx_nco_seq_ctrl.sv
// TX NCO sequencer: clken/sync-clear/phase-increment ownership and IQ-valid gating.
// Define TX_NCO_RAMP_EN to slew retunes in RUN instead of stepping them.
module tx_nco_seq_ctrl
  import tx_nco_seq_ctrl_pkg::*;
#(
  parameter int unsigned APR        = APR_DEF,
  parameter int unsigned LAT        = LAT_DEF,
  parameter int unsigned RAMP_SHIFT = RAMP_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  tx_nco_seq_ctrl_if.slave   bus
);
  localparam int unsigned   CW    = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [APR-1:0] tgt_q, tgt_d;
  logic [APR-1:0] phi_q, phi_d;
  logic           ready_q, ready_d;
  logic           clken_q, clken_d;
  logic           srst_q, srst_d;
  logic           iqv_q, iqv_d;
  logic           busy_q, busy_d;
  logic           accept;

`ifdef TX_NCO_RAMP_EN
  logic [APR-1:0] step_c;

  tx_nco_seq_ctrl_slew #(
    .APR        (APR),
    .RAMP_SHIFT (RAMP_SHIFT)
  ) u_slew (
    .cur       (phi_q),
    .tgt       (tgt_d),
    .phi_nxt_c (step_c)
  );
`else
  localparam int unsigned unused_ramp_shift = RAMP_SHIFT;
`endif

  assign accept = bus.freq_valid_i & ready_q;
  assign tgt_d  = accept ? bus.freq_i : tgt_q;

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    clken_d = clken_q;
    iqv_d   = iqv_q;
    srst_d  = 1'b0;
    if (!bus.en_i) begin
      // Disable wins everywhere; the increment snaps to the (possibly new) target.
      state_d = IDLE;
      clken_d = 1'b0;
      iqv_d   = 1'b0;
      phi_d   = tgt_d;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WARM;
          srst_d  = 1'b1;
          clken_d = 1'b1;
          iqv_d   = 1'b0;
          cnt_d   = '0;
          if (accept) phi_d = bus.freq_i;
        end
        WARM: begin
          clken_d = 1'b1;
          if (accept) phi_d = bus.freq_i;
          if (cnt_q != LAT_C) cnt_d = cnt_q + CW'(1);
          if ((cnt_q == LAT_C) && bus.nco_valid_i) begin
            state_d = RUN;
            iqv_d   = 1'b1;
          end
        end
        RUN: begin
          clken_d = 1'b1;
          iqv_d   = 1'b1;
          if (accept) begin
`ifdef TX_NCO_RAMP_EN
            if (bus.freq_i != phi_q) begin
              phi_d   = step_c;
              state_d = SLEW;
            end
`else
            phi_d = bus.freq_i;
`endif
          end
        end
`ifdef TX_NCO_RAMP_EN
        SLEW: begin
          clken_d = 1'b1;
          iqv_d   = 1'b1;
          if (phi_q == tgt_q) state_d = RUN;
          else                phi_d   = step_c;
        end
`endif
        default: begin
          state_d = IDLE;
          clken_d = 1'b0;
          iqv_d   = 1'b0;
          phi_d   = tgt_d;
        end
      endcase
    end
    ready_d = (state_d != SLEW);
    busy_d  = (state_d == WARM) || (state_d == SLEW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      phi_q   <= '0;
      ready_q <= 1'b1;
      clken_q <= 1'b0;
      srst_q  <= 1'b0;
      iqv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      phi_q   <= phi_d;
      ready_q <= ready_d;
      clken_q <= clken_d;
      srst_q  <= srst_d;
      iqv_q   <= iqv_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.freq_ready_o = ready_q;
  assign bus.nco_clken_o  = clken_q;
  assign bus.nco_srst_o   = srst_q;
  assign bus.phi_inc_o    = phi_q;
  assign bus.iq_valid_o   = iqv_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_tx_nco_seq_ctrl.sv
// Self-checking bench for tx_nco_seq_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model (follows TX_NCO_RAMP_EN like the design).
module tb_tx_nco_seq_ctrl;
  localparam int unsigned APR        = 32;
  localparam int unsigned LAT        = 8;
  localparam int unsigned RAMP_SHIFT = 12;
`ifdef TX_NCO_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam logic [36:0] RST_VEC = {1'b1, 4'b0000, 32'h0};

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  tx_nco_seq_ctrl_if #(.APR(APR)) bus ();

  tx_nco_seq_ctrl #(
    .APR        (APR),
    .LAT        (LAT),
    .RAMP_SHIFT (RAMP_SHIFT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: mode of the sequencer as the spec describes it.
  typedef enum int {M_OFF, M_WARMING, M_LIVE, M_SLEWING} mode_t;
  mode_t       m_mode;
  int          m_warm;
  logic [31:0] m_tgt, m_phi;
  logic        m_ready, m_clken, m_srst, m_iqv, m_busy;

  function automatic void model_reset();
    m_mode  = M_OFF;
    m_warm  = 0;
    m_tgt   = '0;
    m_phi   = '0;
    m_ready = 1'b1;
    m_clken = 1'b0;
    m_srst  = 1'b0;
    m_iqv   = 1'b0;
    m_busy  = 1'b0;
  endfunction

  function automatic logic [31:0] ref_slew(input logic [31:0] cur, input logic [31:0] tgt);
    longint c, t, s, d;
    c = longint'($signed(cur));
    t = longint'($signed(tgt));
    s = longint'(1) << RAMP_SHIFT;
    d = t - c;
    if (d <= s && d >= -s) return tgt;
    return (d > 0) ? 32'(c + s) : 32'(c - s);
  endfunction

  // Advance the model by one clock edge given the inputs present before that edge.
  function automatic void model_clock(input logic en, input logic fv, input logic nv,
                                      input logic [31:0] freq);
    logic acc;
    acc    = fv && m_ready;
    m_srst = 1'b0;
    if (acc) m_tgt = freq;
    if (!en) begin
      m_mode = M_OFF;
      m_phi  = m_tgt;
    end else if (m_mode == M_OFF) begin
      m_mode = M_WARMING;
      m_srst = 1'b1;
      m_warm = 0;
      if (acc) m_phi = freq;
    end else if (m_mode == M_WARMING) begin
      if (acc) m_phi = freq;
      if (m_warm == LAT && nv) m_mode = M_LIVE;
      else if (m_warm < LAT)   m_warm = m_warm + 1;
    end else if (m_mode == M_LIVE) begin
      if (acc) begin
        if (!RAMP) m_phi = freq;
        else if (freq != m_phi) begin
          m_phi  = ref_slew(m_phi, freq);
          m_mode = M_SLEWING;
        end
      end
    end else begin
      if (m_phi == m_tgt) m_mode = M_LIVE;
      else                m_phi  = ref_slew(m_phi, m_tgt);
    end
    m_clken = (m_mode != M_OFF);
    m_iqv   = (m_mode == M_LIVE) || (m_mode == M_SLEWING);
    m_ready = (m_mode != M_SLEWING);
    m_busy  = (m_mode == M_WARMING) || (m_mode == M_SLEWING);
  endfunction

  // Load freq in IDLE, enable, and wait (bounded) for the sample gate to open.
  task automatic go_run(input logic [31:0] freq);
    bit ok;
    bus.en_i         = 1'b0;
    bus.nco_valid_i  = 1'b0;
    bus.freq_i       = freq;
    bus.freq_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.freq_valid_i = 1'b0;
    bus.en_i         = 1'b1;
    bus.nco_valid_i  = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #1;
      ok = bus.iq_valid_o;
    end
    checks++;
    if (!ok || bus.phi_inc_o !== freq) begin
      errors++;
      $display("FAIL go_run: iq_valid=%b phi=%h, required iq_valid=1 phi=%h", ok, bus.phi_inc_o, freq);
    end
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    bus.en_i = 1'b0; bus.freq_valid_i = 1'b0; bus.freq_i = '0; bus.nco_valid_i = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {bus.freq_ready_o, bus.nco_clken_o, bus.nco_srst_o, bus.iq_valid_o, bus.busy_o, bus.phi_inc_o};
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL reset_initial: got %h required %h", obs, RST_VEC);
    end
    reset_n = 1'b1;
    go_run(32'h0147_AE14);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      obs = {bus.freq_ready_o, bus.nco_clken_o, bus.nco_srst_o, bus.iq_valid_o, bus.busy_o, bus.phi_inc_o};
      checks++;
      if (obs !== RST_VEC) begin
        errors++; $display("FAIL reset_mid_run[%0d]: got %h required %h", k, obs, RST_VEC);
      end
      if (k < 3) begin @(posedge clk); #1; end
    end
    bus.en_i = 1'b0; bus.nco_valid_i = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    obs = {bus.freq_ready_o, bus.nco_clken_o, bus.nco_srst_o, bus.iq_valid_o, bus.busy_o, bus.phi_inc_o};
    checks++;
    if (obs !== RST_VEC) begin
      errors++; $display("FAIL reset_release: got %h required %h", obs, RST_VEC);
    end
  endtask

  task automatic test_warmup();
    logic [3:0] obs, exp;
    bus.en_i = 1'b0; bus.nco_valid_i = 1'b0;
    bus.freq_i = 32'h0147_AE14; bus.freq_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.freq_valid_i = 1'b0;
    checks++;
    if (bus.phi_inc_o !== 32'h0147_AE14 || bus.nco_clken_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_load: phi=%h clken=%b required phi=0147ae14 clken=0", bus.phi_inc_o, bus.nco_clken_o);
    end
    bus.en_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      obs = {bus.nco_srst_o, bus.iq_valid_o, bus.nco_clken_o, bus.busy_o};
      exp = {k == 1, k >= 10, 1'b1, k < 10};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL warmup cycle %0d: srst/iqv/clken/busy=%b required %b", k, obs, exp);
      end
      if (k == 8) bus.nco_valid_i = 1'b1;
    end
  endtask

`ifdef TX_NCO_RAMP_EN
  task automatic test_slew();
    logic [31:0] ph_up [5];
    logic [34:0] obs, exp;
    ph_up = '{32'h1000, 32'h2000, 32'h3000, 32'h3800, 32'h3800};
    go_run(32'h0);
    bus.freq_i = 32'h0000_3800; bus.freq_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus.freq_valid_i = 1'b0;
      obs = {bus.freq_ready_o, bus.busy_o, bus.iq_valid_o, bus.phi_inc_o};
      exp = {k == 4, k != 4, 1'b1, ph_up[k]};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL slew_up step %0d: ready/busy/iqv/phi=%h required %h", k, obs, exp);
      end
    end
    go_run(32'h0000_1000);
    bus.freq_i = 32'hFFFF_F000; bus.freq_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.freq_valid_i = 1'b0;
      obs = {bus.freq_ready_o, bus.busy_o, bus.iq_valid_o, bus.phi_inc_o};
      exp = {k == 2, k != 2, 1'b1, (k == 0) ? 32'h0 : 32'hFFFF_F000};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL slew_down step %0d: ready/busy/iqv/phi=%h required %h", k, obs, exp);
      end
    end
    go_run(32'h0);
    bus.freq_i = 32'h0100_0000; bus.freq_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.freq_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.freq_ready_o !== 1'b0 || bus.phi_inc_o !== 32'h2000) begin
      errors++; $display("FAIL slew_mid: ready=%b phi=%h required ready=0 phi=00002000", bus.freq_ready_o, bus.phi_inc_o);
    end
    bus.en_i = 1'b0;
    @(posedge clk); #1;
    obs = {bus.freq_ready_o, bus.busy_o, bus.nco_clken_o, bus.phi_inc_o};
    exp = {1'b1, 1'b0, 1'b0, 32'h0100_0000};
    checks++;
    if (obs !== exp || bus.iq_valid_o !== 1'b0) begin
      errors++; $display("FAIL slew_abort: ready/busy/clken/phi=%h iqv=%b required %h iqv=0", obs, bus.iq_valid_o, exp);
    end
  endtask
`else
  task automatic test_retune();
    logic [34:0] obs, exp;
    bus.freq_i = 32'h0200_0000; bus.freq_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.freq_valid_i = 1'b0;
    obs = {bus.freq_ready_o, bus.iq_valid_o, bus.nco_clken_o, bus.phi_inc_o};
    exp = {1'b1, 1'b1, 1'b1, 32'h0200_0000};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL retune_run: ready/iqv/clken/phi=%h required %h", obs, exp);
    end
    bus.freq_i = 32'hDEAD_0001; bus.freq_valid_i = 1'b1; bus.en_i = 1'b0;
    @(posedge clk); #1;
    bus.freq_valid_i = 1'b0;
    obs = {bus.freq_ready_o, bus.iq_valid_o, bus.nco_clken_o, bus.phi_inc_o};
    exp = {1'b1, 1'b0, 1'b0, 32'hDEAD_0001};
    checks++;
    if (obs !== exp || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL en_fall_accept: ready/iqv/clken/phi=%h busy=%b required %h busy=0", obs, bus.busy_o, exp);
    end
  endtask
`endif

  task automatic test_warm_hold();
    logic [2:0] obs;
    bus.en_i = 1'b0; bus.nco_valid_i = 1'b0; bus.freq_valid_i = 1'b0;
    @(posedge clk); #1;
    bus.en_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      obs = {bus.busy_o, bus.iq_valid_o, bus.nco_clken_o};
      checks++;
      if (obs !== 3'b101) begin
        errors++; $display("FAIL warm_hold cycle %0d: busy/iqv/clken=%b required 101", k, obs);
      end
    end
    bus.en_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [36:0] obs, exp;
    logic        en;
    int          r;
    bus.en_i = 1'b0; bus.freq_valid_i = 1'b0; bus.nco_valid_i = 1'b0; bus.freq_i = '0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      bus.en_i         = en;
      bus.freq_valid_i = ($urandom_range(0, 3) == 0);
      bus.nco_valid_i  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.freq_i = m_phi;
      end else if (RAMP) begin
        r = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
        bus.freq_i = 32'(r);
      end else begin
        bus.freq_i = $urandom;
      end
      model_clock(bus.en_i, bus.freq_valid_i, bus.nco_valid_i, bus.freq_i);
      @(posedge clk); #1;
      obs = {bus.freq_ready_o, bus.nco_clken_o, bus.nco_srst_o, bus.iq_valid_o, bus.busy_o, bus.phi_inc_o};
      exp = {m_ready, m_clken, m_srst, m_iqv, m_busy, m_phi};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random cycle %0d: ready/clken/srst/iqv/busy/phi=%h required %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
`ifdef TX_NCO_RAMP_EN
    test_slew();
`else
    test_retune();
`endif
    test_warm_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
